// File: rtl/ascon_stream_frontend_if.sv
// Request/response stream bundle between a frame source/sink and the Ascon front end.
interface ascon_stream_frontend_if;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [63:0] m_data;

    modport master (
        output s_valid, s_last, s_data, m_ready,
        input  s_ready, m_valid, m_last, m_data
    );

    modport slave (
        input  s_valid, s_last, s_data, m_ready,
        output s_ready, m_valid, m_last, m_data
    );
endinterface

// File: rtl/ascon_stream_frontend.sv
// Frames a request stream into Ascon core operands, sequences the core and
// streams back a status word plus ciphertext/tag or plaintext.
module ascon_stream_frontend #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ascon_stream_frontend_if.slave bus,
    output logic                   core_start,
    output logic [1:0]             core_mode,
    output logic [127:0]           core_key,
    output logic [127:0]           core_nonce,
    output logic [63:0]            core_ad   [0:1],
    output logic [63:0]            core_text [0:1],
    input  logic [63:0]            core_ct   [0:1],
    input  logic [63:0]            core_tag  [0:1],
    input  logic [63:0]            core_pt   [0:1],
    input  logic                   core_done,
    input  logic                   core_error
);
    typedef enum logic [2:0] {ST_RECV, ST_START, ST_WAIT, ST_SEND, ST_DRAIN} state_t;

    state_t       state_q, state_d;
    logic [3:0]   widx_q, widx_d;
    logic [1:0]   mode_q, mode_d;
    logic [127:0] key_q, key_d, nonce_q, nonce_d;
    logic [63:0]  ad_q [0:1], ad_d [0:1];
    logic [63:0]  text_q [0:1], text_d [0:1];
    logic [63:0]  rtag_q [0:1], rtag_d [0:1];
    logic [63:0]  rsp_q [0:3], rsp_d [0:3];
    logic [2:0]   rsp_len_q, rsp_len_d, ridx_q, ridx_d;
    logic [15:0]  timer_q, timer_d;
    logic [4:0]   status_q, status_d;
    logic         s_ready_q, s_ready_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [63:0]  m_data_q, m_data_d;
    logic         core_start_q, core_start_d;
    logic [1:0]   core_mode_q, core_mode_d;
    logic         s_hs_s, m_hs_s, auth_fail_s, pt_kill_s;
    logic [3:0]   final_idx_s;
    logic [1:0]   rsel_s;

    // Next-state, operand capture and response staging.
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        mode_d      = mode_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        ad_d        = ad_q;
        text_d      = text_q;
        rtag_d      = rtag_q;
        rsp_d       = rsp_q;
        rsp_len_d   = rsp_len_q;
        ridx_d      = ridx_q;
        timer_d     = timer_q;
        status_d    = status_q;
        core_mode_d = core_mode_q;
        s_hs_s      = bus.s_valid && s_ready_q;
        m_hs_s      = m_valid_q && bus.m_ready;
        final_idx_s = (mode_q == 2'd1) ? 4'd10 : 4'd8;
        auth_fail_s = (mode_q == 2'd1) &&
                      ({core_tag[0], core_tag[1]} != {rtag_q[0], rtag_q[1]});
        pt_kill_s   = auth_fail_s || core_error;

        case (state_q)
            ST_RECV: begin
                if (s_hs_s) begin
                    widx_d = widx_q + 4'd1;
                    if (widx_q == 4'd0) begin
                        mode_d = bus.s_data[1:0];
                        if (bus.s_data[1:0] >= 2'd2) begin
                            status_d[2] = 1'b1;
                            rsp_len_d   = 3'd1;
                            state_d     = bus.s_last ? ST_SEND : ST_DRAIN;
                        end else if (bus.s_last) begin
                            status_d[3] = 1'b1;
                            rsp_len_d   = 3'd1;
                            state_d     = ST_SEND;
                        end else begin
                            state_d = ST_RECV;
                        end
                    end else begin
                        case (widx_q)
                            4'd1:    key_d[127:64]   = bus.s_data;
                            4'd2:    key_d[63:0]     = bus.s_data;
                            4'd3:    nonce_d[127:64] = bus.s_data;
                            4'd4:    nonce_d[63:0]   = bus.s_data;
                            4'd5:    ad_d[0]         = bus.s_data;
                            4'd6:    ad_d[1]         = bus.s_data;
                            4'd7:    text_d[0]       = bus.s_data;
                            4'd8:    text_d[1]       = bus.s_data;
                            4'd9:    rtag_d[0]       = bus.s_data;
                            4'd10:   rtag_d[1]       = bus.s_data;
                            default: rtag_d          = rtag_q;
                        endcase
                        if (bus.s_last && (widx_q != final_idx_s)) begin
                            status_d[3] = 1'b1;
                            rsp_len_d   = 3'd1;
                            state_d     = ST_SEND;
                        end else if ((widx_q == final_idx_s) && !bus.s_last) begin
                            status_d[3] = 1'b1;
                            rsp_len_d   = 3'd1;
                            state_d     = ST_DRAIN;
                        end else if (widx_q == final_idx_s) begin
                            core_mode_d = mode_q;
                            state_d     = ST_START;
                        end else begin
                            state_d = ST_RECV;
                        end
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_START: begin
                // The START cycle counts toward the timeout budget.
                timer_d = 16'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    status_d    = {status_q[4:2], core_error, auth_fail_s};
                    core_mode_d = 2'd2;
                    state_d     = ST_SEND;
                    if (mode_q == 2'd0) begin
                        rsp_d     = '{core_ct[0], core_ct[1], core_tag[0], core_tag[1]};
                        rsp_len_d = 3'd5;
                    end else begin
                        rsp_d[0]  = pt_kill_s ? 64'd0 : core_pt[0];
                        rsp_d[1]  = pt_kill_s ? 64'd0 : core_pt[1];
                        rsp_len_d = 3'd3;
                    end
                end else if (timer_q >= 16'(TIMEOUT_CYC - 1)) begin
                    status_d[4] = 1'b1;
                    rsp_len_d   = 3'd1;
                    core_mode_d = 2'd2;
                    state_d     = ST_SEND;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_SEND: begin
                if (m_hs_s && (ridx_q == rsp_len_q - 3'd1)) begin
                    ridx_d   = 3'd0;
                    widx_d   = 4'd0;
                    status_d = 5'd0;
                    state_d  = ST_RECV;
                end else if (m_hs_s) begin
                    ridx_d = ridx_q + 3'd1;
                end else begin
                    ridx_d = ridx_q;
                end
            end
            ST_DRAIN: begin
                if (s_hs_s && bus.s_last) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    // Registered stream and core-control outputs derived from the next state.
    always_comb begin
        s_ready_d    = (state_d == ST_RECV) || (state_d == ST_DRAIN);
        core_start_d = (state_d == ST_START);
        m_valid_d    = 1'b0;
        m_last_d     = 1'b0;
        m_data_d     = 64'd0;
        rsel_s       = 2'd0;
        if (state_d == ST_SEND) begin
            m_valid_d = 1'b1;
            m_last_d  = (ridx_d == rsp_len_d - 3'd1);
            if (ridx_d == 3'd0) begin
                m_data_d = {59'd0, status_d};
            end else begin
                rsel_s   = 2'(ridx_d - 3'd1);
                m_data_d = rsp_d[rsel_s];
            end
        end else begin
            m_data_d = 64'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RECV;
            widx_q       <= 4'd0;
            mode_q       <= 2'd0;
            key_q        <= 128'd0;
            nonce_q      <= 128'd0;
            ad_q         <= '{default: 64'd0};
            text_q       <= '{default: 64'd0};
            rtag_q       <= '{default: 64'd0};
            rsp_q        <= '{default: 64'd0};
            rsp_len_q    <= 3'd0;
            ridx_q       <= 3'd0;
            timer_q      <= 16'd0;
            status_q     <= 5'd0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= 64'd0;
            core_start_q <= 1'b0;
            core_mode_q  <= 2'd2;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            mode_q       <= mode_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            ad_q         <= ad_d;
            text_q       <= text_d;
            rtag_q       <= rtag_d;
            rsp_q        <= rsp_d;
            rsp_len_q    <= rsp_len_d;
            ridx_q       <= ridx_d;
            timer_q      <= timer_d;
            status_q     <= status_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            core_start_q <= core_start_d;
            core_mode_q  <= core_mode_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_data  = m_data_q;
    assign core_start  = core_start_q;
    assign core_mode   = core_mode_q;
    assign core_key    = key_q;
    assign core_nonce  = nonce_q;
    assign core_ad     = ad_q;
    assign core_text   = text_q;
endmodule

// File: tb/tb_ascon_stream_frontend.sv
// Randomized frame-level bench for ascon_stream_frontend with a core model and
// a response reference model built from the framing rules.
module tb_ascon_stream_frontend;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    ascon_stream_frontend_if sif();
    logic         core_start;
    logic [1:0]   core_mode;
    logic [127:0] core_key, core_nonce;
    logic [63:0]  core_ad [0:1], core_text [0:1];
    logic [63:0]  core_ct [0:1], core_tag [0:1], core_pt [0:1];
    logic         core_done, core_error;

    ascon_stream_frontend #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(sif),
        .core_start(core_start), .core_mode(core_mode),
        .core_key(core_key), .core_nonce(core_nonce),
        .core_ad(core_ad), .core_text(core_text),
        .core_ct(core_ct), .core_tag(core_tag), .core_pt(core_pt),
        .core_done(core_done), .core_error(core_error)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    longint      cyc = 0;
    logic [63:0] fw [0:15];
    int          last_pos;
    logic [63:0] ct_v [0:1], tag_v [0:1], pt_v [0:1];
    logic        err_v;
    bit          never_done = 1'b0;
    int          done_dly = 20;
    int          rdy_mode = 0;
    logic [63:0] rx_q [$];
    bit          rxl_q [$];
    logic [63:0] exp_q [$];
    bit          exp_start;
    int          start_cnt = 0;
    longint      start_cyc = 0;
    longint      mv_rise_cyc = 0;
    bit          pend = 1'b0;
    bit          pv = 1'b0;
    logic [63:0] pd;
    logic        pl;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: checks operands at start, answers after done_dly cycles.
    initial begin
        logic [63:0] h;
        core_done  = 1'b0;
        core_error = 1'b0;
        core_ct    = '{default: 64'd0};
        core_tag   = '{default: 64'd0};
        core_pt    = '{default: 64'd0};
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
                h = fw[0];
                check_eq("start_mode", 64'(core_mode), 64'(h[1:0]));
                check_eq("start_key_hi", core_key[127:64], fw[1]);
                check_eq("start_key_lo", core_key[63:0], fw[2]);
                check_eq("start_nonce_hi", core_nonce[127:64], fw[3]);
                check_eq("start_nonce_lo", core_nonce[63:0], fw[4]);
                check_eq("start_ad0", core_ad[0], fw[5]);
                check_eq("start_ad1", core_ad[1], fw[6]);
                check_eq("start_text0", core_text[0], fw[7]);
                check_eq("start_text1", core_text[1], fw[8]);
                @(negedge clk);
                check_eq("start_pulse", 64'(core_start), 64'd0);
                if (!never_done) begin
                    repeat (done_dly - 1) @(negedge clk);
                    check_eq("mode_hold", 64'(core_mode), 64'(h[1:0]));
                    check_eq("key_hold", core_key[63:0], fw[2]);
                    core_ct    = ct_v;
                    core_tag   = tag_v;
                    core_pt    = pt_v;
                    core_error = err_v;
                    core_done  = 1'b1;
                end
            end
        end
    end

    // Response sink: drives m_ready, records accepted words, checks hold-until-accepted.
    initial begin
        sif.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check_eq("hold_valid", 64'(sif.m_valid), 64'd1);
                check_eq("hold_data", sif.m_data, pd);
                check_eq("hold_last", 64'(sif.m_last), 64'(pl));
            end
            if (sif.m_valid && !pv) mv_rise_cyc = cyc;
            pv = sif.m_valid;
            case (rdy_mode)
                0:       sif.m_ready = 1'b1;
                1:       sif.m_ready = ~sif.m_ready;
                default: sif.m_ready = 1'($urandom_range(0, 1));
            endcase
            if (sif.m_valid && sif.m_ready) begin
                rx_q.push_back(sif.m_data);
                rxl_q.push_back(sif.m_last);
                pend = 1'b0;
            end else begin
                pend = sif.m_valid;
                pd   = sif.m_data;
                pl   = sif.m_last;
            end
        end
    end

    task automatic push(input logic [63:0] d, input logic l);
        int b = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = l;
        while (!sif.s_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        check_eq("s_ready", 64'(sif.s_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_words();
        for (int i = 0; i <= last_pos; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sif.s_valid = 1'b0;
                @(negedge clk);
            end
            push(fw[i], i == last_pos);
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    // kind: 0 enc, 1 dec match, 2 dec tag flip, 3 bad header, 4 length error
    task automatic build(input int kind);
        int need;
        for (int i = 0; i < 16; i++) fw[i] = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            ct_v[i]  = {$urandom, $urandom};
            tag_v[i] = {$urandom, $urandom};
            pt_v[i]  = {$urandom, $urandom};
        end
        err_v      = ($urandom_range(0, 3) == 0);
        never_done = 1'b0;
        case (kind)
            0: begin fw[0][1:0] = 2'd0; last_pos = 8; end
            1, 2: begin
                fw[0][1:0] = 2'd1;
                last_pos   = 10;
                fw[9]      = tag_v[0];
                fw[10]     = tag_v[1];
                if (kind == 2) fw[9 + $urandom_range(0, 1)][$urandom_range(0, 63)] ^= 1'b1;
            end
            3: begin fw[0][1:0] = 2'd2 + 2'($urandom_range(0, 1)); last_pos = $urandom_range(0, 6); end
            default: begin
                fw[0][1:0] = 2'($urandom_range(0, 1));
                need = (fw[0][1:0] == 2'd0) ? 9 : 11;
                do last_pos = $urandom_range(0, 13); while (last_pos == need - 1);
            end
        endcase
    endtask

    task automatic model_build();
        logic [63:0] h;
        logic [1:0]  mode;
        int          need;
        bit          auth;
        logic [63:0] st;
        h = fw[0];
        mode = h[1:0];
        need = (mode == 2'd0) ? 9 : 11;
        exp_q.delete();
        exp_start = 1'b0;
        if (mode >= 2'd2) exp_q.push_back(64'h4);
        else if (last_pos + 1 != need) exp_q.push_back(64'h8);
        else begin
            exp_start = 1'b1;
            if (never_done) exp_q.push_back(64'h10);
            else begin
                auth = (mode == 2'd1) && ({fw[9], fw[10]} != {tag_v[0], tag_v[1]});
                st   = {62'd0, err_v, auth};
                exp_q.push_back(st);
                if (mode == 2'd0) begin
                    exp_q.push_back(ct_v[0]);  exp_q.push_back(ct_v[1]);
                    exp_q.push_back(tag_v[0]); exp_q.push_back(tag_v[1]);
                end else begin
                    exp_q.push_back((auth || err_v) ? 64'd0 : pt_v[0]);
                    exp_q.push_back((auth || err_v) ? 64'd0 : pt_v[1]);
                end
            end
        end
    endtask

    task automatic run_frame();
        int base, s0, b;
        model_build();
        base = rx_q.size();
        s0   = start_cnt;
        send_words();
        b = 0;
        while (rx_q.size() - base < exp_q.size() && b < 300) begin
            @(negedge clk);
            b++;
        end
        check_eq("rsp_count", 64'(rx_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
            check_eq("rsp_word", rx_q[base + i], exp_q[i]);
            check_eq("rsp_last", 64'(rxl_q[base + i]), 64'(i == exp_q.size() - 1));
        end
        repeat (2) @(negedge clk);
        check_eq("start_count", 64'(start_cnt - s0), 64'(exp_start));
        check_eq("idle_mode", 64'(core_mode), 64'd2);
        check_eq("idle_ready", 64'(sif.s_ready), 64'd1);
    endtask

    initial begin
        int base;
        rst_n       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_data  = 64'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_s_ready", 64'(sif.s_ready), 64'd0);
        check_eq("rst_m_valid", 64'(sif.m_valid), 64'd0);
        check_eq("rst_m_data", sif.m_data, 64'd0);
        check_eq("rst_core_mode", 64'(core_mode), 64'd2);
        check_eq("rst_core_start", 64'(core_start), 64'd0);
        check_eq("rst_core_key", core_key[63:0], 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(sif.s_ready), 64'd1);

        build(0);
        err_v = 1'b0;
        fw[0] = 64'd0;
        fw[1] = 64'h1234567890ABCDEF; fw[2] = 64'h1234567890ABCDEF;
        fw[3] = 64'hFEDCBA9876543210; fw[4] = 64'hFEDCBA9876543210;
        fw[5] = 64'h41757468656E74;   fw[6] = 64'h6963617465642121;
        fw[7] = 64'h436F6E666964656E; fw[8] = 64'h7469616C44617461;
        run_frame();

        build(1); err_v = 1'b0; run_frame();
        build(2); err_v = 1'b0; run_frame();

        build(3); fw[0][1:0] = 2'd3; last_pos = 4; run_frame();

        build(0); last_pos = 5; run_frame();
        build(0); run_frame();

        build(0); never_done = 1'b1; run_frame();
        check_eq("timeout_lat", 64'(mv_rise_cyc - start_cyc), 64'd64);

        rdy_mode = 1;
        build(0); run_frame();
        build(1); run_frame();

        build(0);
        never_done = 1'b1;
        base = rx_q.size();
        send_words();
        repeat (10) @(negedge clk);
        check_eq("wait_mode", 64'(core_mode), 64'd0);
        check_eq("wait_ready", 64'(sif.s_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", 64'(sif.s_ready), 64'd0);
        check_eq("mid_rst_mode", 64'(core_mode), 64'd2);
        check_eq("mid_rst_valid", 64'(sif.m_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", 64'(sif.s_ready), 64'd1);
        repeat (100) @(negedge clk);
        check_eq("no_rsp_after_rst", 64'(rx_q.size() - base), 64'd0);
        check_eq("rel_mode", 64'(core_mode), 64'd2);
        never_done = 1'b0;

        for (int n = 0; n < 40; n++) begin
            rdy_mode = $urandom_range(0, 2);
            build($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) never_done = 1'b1;
            run_frame();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
